opc7_bus_responder: RTL and testbench

- Bus target for the opc7 CPU: services instruction fetch (vpa), data (vda) and I/O (vio) cycles.
- Paces the CPU through clken, using programmable wait states.
- Contains a word-addressed internal RAM and a small I/O register block: interval timer, interrupt control, scratch register.
- Drives the CPU's active-low int_b[1:0] interrupt lines.

---
 rtl/opc7_bus_if.sv | 23 ++
 rtl/opc7_bus_responder.sv | 177 +++++++++++++++++
 tb/tb_opc7_bus_responder.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/opc7_bus_if.sv
// opc7 CPU bus: fetch/data/IO cycle strobes, read/write data, clken pacing
// and the active-low interrupt lines back to the CPU.
interface opc7_bus_if;
  logic [19:0] address;
  logic [31:0] dout;
  logic        rnw;
  logic        vpa;
  logic        vda;
  logic        vio;
  logic [31:0] din;
  logic        clken;
  logic [1:0]  int_b;

  modport master (
    output address, dout, rnw, vpa, vda, vio,
    input  din, clken, int_b
  );

  modport slave (
    input  address, dout, rnw, vpa, vda, vio,
    output din, clken, int_b
  );
endinterface

// File: rtl/opc7_bus_responder.sv
// opc7 bus target: wait-stated RAM plus timer/irq/scratch I/O block.
// Optional bus-error reporting is built when OPC7_BUS_RESP_BUSERR_EN is defined.
module opc7_bus_responder #(
  parameter int MEM_AW   = 10,
  parameter int MEM_WAIT = 1,
  parameter int IO_WAIT  = 2,
  parameter int TIMER_W  = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      ext_irq,
  opc7_bus_if.slave bus
);

`ifdef OPC7_BUS_RESP_BUSERR_EN
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif

  localparam logic [3:0] CTRL_MASK = BE ? 4'hf : 4'h7;
  localparam logic [2:0] ST_MASK   = BE ? 3'h7 : 3'h3;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK
  } state_t;

  state_t state, nstate;
  logic [3:0] wcnt, wcnt_n;

  logic        io_q, rnw_q, inram_q;
  logic [19:0] addr_q;
  logic [31:0] wdata_q, rd_q, din_q;

  logic [TIMER_W-1:0] tload, tcnt;
  logic [3:0]  ctrl;
  logic [2:0]  status;
  logic [31:0] scratch;
  logic        sync1, sync2, sync3;
  logic [1:0]  int_b_q;

  logic [31:0] mem [2**MEM_AW];

  logic        access, in_ram, clken;
  logic [31:0] io_rd, rd_now;
  logic        commit, io_wr, mem_wr;
  logic [3:0]  io_sel;
  logic        t_set, e_set, b_set;
  logic [2:0]  st_clr;

  assign access = bus.vpa | bus.vda | bus.vio;
  assign in_ram = (32'(bus.address) >> MEM_AW) == 32'd0;

  always_comb begin
    io_rd = 32'd0;
    case (bus.address[3:0])
      4'd0: io_rd = 32'(tload);
      4'd1: io_rd = 32'(tcnt);
      4'd2: io_rd = 32'(ctrl);
      4'd3: io_rd = 32'(status);
      4'd4: io_rd = scratch;
      default: io_rd = 32'd0;
    endcase
  end

  always_comb begin
    rd_now = 32'd0;
    if (bus.vio)
      rd_now = io_rd;
    else if (in_ram)
      rd_now = mem[bus.address[MEM_AW-1:0]];
  end

  always_comb begin
    nstate = state;
    wcnt_n = wcnt;
    unique case (state)
      IDLE: begin
        if (access) begin
          wcnt_n = bus.vio ? 4'(IO_WAIT) : 4'(MEM_WAIT);
          nstate = (wcnt_n != 4'd0) ? WAIT : ACK;
        end
      end
      WAIT: begin
        wcnt_n = wcnt - 4'd1;
        if (wcnt == 4'd1)
          nstate = ACK;
      end
      ACK:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  assign clken = (state == ACK) | ((state == IDLE) & ~access);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      wcnt    <= 4'd0;
      io_q    <= 1'b0;
      rnw_q   <= 1'b1;
      inram_q <= 1'b0;
      addr_q  <= 20'd0;
      wdata_q <= 32'd0;
      rd_q    <= 32'd0;
      din_q   <= 32'd0;
    end else begin
      state <= nstate;
      wcnt  <= wcnt_n;
      if (state == IDLE && access) begin
        io_q    <= bus.vio;
        rnw_q   <= bus.rnw;
        inram_q <= in_ram;
        addr_q  <= bus.address;
        wdata_q <= bus.dout;
        rd_q    <= rd_now;
      end
      // Zero-wait accesses reach ACK straight from IDLE and bypass rd_q.
      if (nstate == ACK && state != ACK)
        din_q <= (state == IDLE) ? rd_now : rd_q;
    end
  end

  assign commit = (state == ACK) & ~rnw_q;
  assign io_wr  = commit & io_q;
  assign mem_wr = commit & ~io_q & inram_q;
  assign io_sel = addr_q[3:0];

  always_ff @(posedge clk) begin
    if (mem_wr)
      mem[addr_q[MEM_AW-1:0]] <= wdata_q;
  end

  assign t_set  = ctrl[0] & (tcnt == '0);
  assign e_set  = sync2 & ~sync3;
  assign b_set  = BE & (state == ACK) & ~io_q & ~inram_q;
  assign st_clr = (io_wr && io_sel == 4'd3) ? wdata_q[2:0] : 3'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tload   <= '0;
      tcnt    <= '0;
      ctrl    <= 4'd0;
      status  <= 3'd0;
      scratch <= 32'd0;
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync3   <= 1'b0;
      int_b_q <= 2'b11;
    end else begin
      sync1 <= ext_irq;
      sync2 <= sync1;
      sync3 <= sync2;
      if (io_wr && io_sel == 4'd0) begin
        tload <= wdata_q[TIMER_W-1:0];
        tcnt  <= wdata_q[TIMER_W-1:0];
      end else if (ctrl[0]) begin
        tcnt <= (tcnt == '0) ? tload : tcnt - TIMER_W'(1);
      end
      if (io_wr && io_sel == 4'd2)
        ctrl <= wdata_q[3:0] & CTRL_MASK;
      if (io_wr && io_sel == 4'd4)
        scratch <= wdata_q;
      // Set terms are OR-ed after the clear so a coincident set survives.
      status <= ((status & ~st_clr) | {b_set, e_set, t_set}) & ST_MASK;
      int_b_q[0] <= ~((status[0] & ctrl[1]) | (status[2] & ctrl[3]));
      int_b_q[1] <= ~(status[1] & ctrl[2]);
    end
  end

  assign bus.din   = din_q;
  assign bus.clken = clken;
  assign bus.int_b = int_b_q;

endmodule

// File: tb/tb_opc7_bus_responder.sv
// Randomised self-checking bench for opc7_bus_responder with a
// transaction-level RAM/IO reference model.
module tb_opc7_bus_responder;

  localparam int MEM_AW   = 10;
  localparam int MEM_WAIT = 1;
  localparam int IO_WAIT  = 2;
  localparam int TIMER_W  = 16;
  localparam int RAM_WORDS = 1 << MEM_AW;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ext_irq = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [int];

  opc7_bus_if bus ();

  opc7_bus_responder #(
    .MEM_AW  (MEM_AW),
    .MEM_WAIT(MEM_WAIT),
    .IO_WAIT (IO_WAIT),
    .TIMER_W (TIMER_W)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ext_irq(ext_irq),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic bus_op(input bit io, input bit fetch,
                        input logic [19:0] a, input bit rd,
                        input logic [31:0] wd,
                        output logic [31:0] rdat, output int ncyc);
    bit ok;
    @(negedge clk);
    bus.address = a;
    bus.dout    = wd;
    bus.rnw     = rd;
    bus.vio     = io;
    bus.vpa     = fetch & ~io;
    bus.vda     = ~fetch & ~io;
    ncyc = 0;
    ok   = 1'b0;
    rdat = 32'd0;
    for (int i = 0; i < 40; i++) begin
      #1;
      ncyc++;
      if (bus.clken === 1'b1) begin
        rdat = bus.din;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bus_timeout addr=%h: no clken within 40 cycles", a);
    end
    @(posedge clk);
    #1;
    bus.vpa = 1'b0;
    bus.vda = 1'b0;
    bus.vio = 1'b0;
    bus.rnw = 1'b1;
  endtask

  task automatic mem_write(input logic [19:0] a, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    bus_op(1'b0, 1'b0, a, 1'b0, wd, r, n);
    if (int'(a) < RAM_WORDS) ref_mem[int'(a)] = wd;
  endtask

  task automatic io_write(input logic [3:0] reg_a, input logic [31:0] wd);
    logic [31:0] r;
    int n;
    bus_op(1'b1, 1'b0, {16'h0, reg_a}, 1'b0, wd, r, n);
  endtask

  task automatic test_reset;
    checks++;
    if (bus.clken !== 1'b1 || bus.int_b !== 2'b11 || bus.din !== 32'd0) begin
      errors++;
      $display("FAIL reset_state clken=%b int_b=%b din=%h want 1 11 0",
               bus.clken, bus.int_b, bus.din);
    end
  endtask

  task automatic test_fetch;
    logic [31:0] r;
    int n;
    mem_write(20'h00005, 32'h12345678);
    bus_op(1'b0, 1'b1, 20'h00005, 1'b1, 32'd0, r, n);
    checks++;
    if (r !== 32'h12345678) begin
      errors++;
      $display("FAIL fetch_data got %h want 12345678", r);
    end
    checks++;
    if (n !== 2 + MEM_WAIT) begin
      errors++;
      $display("FAIL fetch_latency got %0d want %0d", n, 2 + MEM_WAIT);
    end
  endtask

  task automatic test_memory;
    logic [31:0] r;
    int n;
    mem_write(20'h00010, 32'hDEADBEEF);
    bus_op(1'b0, 1'b0, 20'h00010, 1'b1, 32'd0, r, n);
    checks++;
    if (r !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL mem_rw got %h want deadbeef", r);
    end
    mem_write(20'h00400, 32'hCAFEF00D);
    bus_op(1'b0, 1'b0, 20'h00400, 1'b1, 32'd0, r, n);
    checks++;
    if (r !== 32'd0) begin
      errors++;
      $display("FAIL mem_oor_read got %h want 0", r);
    end
    bus_op(1'b0, 1'b0, 20'h00000, 1'b1, 32'd0, r, n);
    if (ref_mem.exists(0)) begin
      checks++;
      if (r !== ref_mem[0]) begin
        errors++;
        $display("FAIL mem_alias got %h want %h", r, ref_mem[0]);
      end
    end
  endtask

  task automatic test_timer;
    logic [31:0] r;
    int n;
    int l;
    l = $urandom_range(2, 6);
    io_write(4'd3, 32'h7);
    io_write(4'd0, 32'(l));
    io_write(4'd2, 32'h3);
    for (int k = 1; k <= l + 4; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.int_b[0] !== ((k >= l + 2) ? 1'b0 : 1'b1)) begin
        errors++;
        $display("FAIL timer_irq load=%0d cycle=%0d got %b want %b",
                 l, k, bus.int_b[0], (k >= l + 2) ? 1'b0 : 1'b1);
      end
    end
    io_write(4'd2, 32'h2);
    bus_op(1'b1, 1'b0, 20'h00003, 1'b1, 32'd0, r, n);
    checks++;
    if (r !== 32'h1) begin
      errors++;
      $display("FAIL timer_status got %h want 1", r);
    end
    checks++;
    if (n !== 2 + IO_WAIT) begin
      errors++;
      $display("FAIL io_latency got %0d want %0d", n, 2 + IO_WAIT);
    end
    bus_op(1'b1, 1'b0, 20'hABC00, 1'b1, 32'd0, r, n);
    checks++;
    if (r !== 32'(l)) begin
      errors++;
      $display("FAIL timer_load_rd got %h want %h", r, l);
    end
    io_write(4'd3, 32'h1);
    checks++;
    if (bus.int_b[0] !== 1'b0) begin
      errors++;
      $display("FAIL w1c_delay got %b want 0", bus.int_b[0]);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.int_b !== 2'b11) begin
      errors++;
      $display("FAIL w1c_clear got %b want 11", bus.int_b);
    end
  endtask

  task automatic test_scratch;
    logic [31:0] r;
    logic [31:0] v;
    int n;
    v = $urandom;
    io_write(4'd4, v);
    bus_op(1'b1, 1'b0, 20'h00004, 1'b1, 32'd0, r, n);
    checks++;
    if (r !== v) begin
      errors++;
      $display("FAIL scratch got %h want %h", r, v);
    end
    io_write(4'd7, 32'hFFFFFFFF);
    bus_op(1'b1, 1'b0, 20'h00007, 1'b1, 32'd0, r, n);
    checks++;
    if (r !== 32'd0) begin
      errors++;
      $display("FAIL unmapped got %h want 0", r);
    end
  endtask

  task automatic test_ext_irq;
    logic [31:0] r;
    int n;
    io_write(4'd3, 32'h7);
    io_write(4'd2, 32'h4);
    @(negedge clk);
    ext_irq = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bus.int_b !== ((k >= 4) ? 2'b01 : 2'b11)) begin
        errors++;
        $display("FAIL ext_irq cycle=%0d got %b want %b",
                 k, bus.int_b, (k >= 4) ? 2'b01 : 2'b11);
      end
    end
    ext_irq = 1'b0;
    bus_op(1'b1, 1'b0, 20'h00003, 1'b1, 32'd0, r, n);
    checks++;
    if (r !== 32'h2) begin
      errors++;
      $display("FAIL ext_status got %h want 2", r);
    end
    io_write(4'd3, 32'h2);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.int_b !== 2'b11) begin
      errors++;
      $display("FAIL ext_clear got %b want 11", bus.int_b);
    end
    fork
      io_write(4'd3, 32'h2);
      begin
        @(negedge clk);
        @(negedge clk);
        ext_irq = 1'b1;
      end
    join
    bus_op(1'b1, 1'b0, 20'h00003, 1'b1, 32'd0, r, n);
    checks++;
    if (r !== 32'h2) begin
      errors++;
      $display("FAIL set_wins got %h want 2", r);
    end
    checks++;
    if (bus.int_b !== 2'b01) begin
      errors++;
      $display("FAIL set_wins_irq got %b want 01", bus.int_b);
    end
    ext_irq = 1'b0;
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] r;
    int n;
    mem_write(20'h00020, 32'hA5A5_0F0F);
    @(negedge clk);
    bus.address = 20'h00020;
    bus.dout    = 32'h5A5A_F0F0;
    bus.rnw     = 1'b0;
    bus.vda     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset   = 1'b1;
    bus.vda = 1'b0;
    bus.rnw = 1'b1;
    #1;
    checks++;
    if (bus.clken !== 1'b1 || bus.int_b !== 2'b11) begin
      errors++;
      $display("FAIL reset_mid clken=%b int_b=%b want 1 11",
               bus.clken, bus.int_b);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus_op(1'b0, 1'b0, 20'h00020, 1'b1, 32'd0, r, n);
    checks++;
    if (r !== ref_mem[32]) begin
      errors++;
      $display("FAIL reset_discard got %h want %h", r, ref_mem[32]);
    end
  endtask

  task automatic test_buserr;
    logic [31:0] r;
    int n;
    io_write(4'd3, 32'h7);
    io_write(4'd2, 32'h8);
    bus_op(1'b0, 1'b0, 20'hFFFFF, 1'b1, 32'd0, r, n);
    checks++;
    if (r !== 32'd0) begin
      errors++;
      $display("FAIL buserr_data got %h want 0", r);
    end
    bus_op(1'b1, 1'b0, 20'h00003, 1'b1, 32'd0, r, n);
    @(posedge clk);
    #1;
`ifdef OPC7_BUS_RESP_BUSERR_EN
    checks++;
    if (r !== 32'h4) begin
      errors++;
      $display("FAIL buserr_status got %h want 4", r);
    end
    checks++;
    if (bus.int_b !== 2'b10) begin
      errors++;
      $display("FAIL buserr_irq got %b want 10", bus.int_b);
    end
`else
    checks++;
    if (r !== 32'h0) begin
      errors++;
      $display("FAIL buserr_status got %h want 0", r);
    end
    checks++;
    if (bus.int_b !== 2'b11) begin
      errors++;
      $display("FAIL buserr_irq got %b want 11", bus.int_b);
    end
`endif
  endtask

  task automatic test_random_mem;
    logic [31:0] r;
    logic [31:0] wd;
    logic [19:0] a;
    int n;
    bit rd;
    bit fetch;
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 1) == 1) ? 20'($urandom_range(0, 15))
                                      : 20'($urandom_range(0, 2047));
      rd    = $urandom_range(0, 1) == 1;
      fetch = rd && ($urandom_range(0, 1) == 1);
      wd    = $urandom;
      bus_op(1'b0, fetch, a, rd, wd, r, n);
      checks++;
      if (n !== 2 + MEM_WAIT) begin
        errors++;
        $display("FAIL rand_latency addr=%h got %0d want %0d",
                 a, n, 2 + MEM_WAIT);
      end
      if (!rd) begin
        if (int'(a) < RAM_WORDS) ref_mem[int'(a)] = wd;
      end else if (int'(a) >= RAM_WORDS) begin
        checks++;
        if (r !== 32'd0) begin
          errors++;
          $display("FAIL rand_oor addr=%h got %h want 0", a, r);
        end
      end else if (ref_mem.exists(int'(a))) begin
        checks++;
        if (r !== ref_mem[int'(a)]) begin
          errors++;
          $display("FAIL rand_read addr=%h got %h want %h",
                   a, r, ref_mem[int'(a)]);
        end
      end
    end
  endtask

  initial begin
    bus.address = 20'd0;
    bus.dout    = 32'd0;
    bus.rnw     = 1'b1;
    bus.vpa     = 1'b0;
    bus.vda     = 1'b0;
    bus.vio     = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    test_reset();
    test_fetch();
    test_memory();
    test_timer();
    test_scratch();
    test_ext_irq();
    test_reset_mid_write();
    test_buserr();
    test_random_mem();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
